// File: rtl/ram_responder.sv
// Word-organised RAM behind a fixed-latency IDLE/BUSY/DONE request handshake.
// Define RAM_RESPONDER_BOUNDS_CHECK_EN to reject out-of-range accesses instead of wrapping.
module ram_responder #(
  parameter int unsigned WORDS   = 1024,
  parameter int unsigned LATENCY = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] input_data,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  mem_op_length,
  output logic [31:0] output_data,
  output logic        stall,
  output logic        ready,
  output logic        error
);

  localparam int unsigned AW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic [AW+1:0] lat_addr;
  logic [31:0]   lat_data;
  logic [2:0]    lat_len;
  logic          lat_wr;
  logic          lat_rd;

  logic [31:0]   mem [WORDS];

  logic          req;
  logic          fire;
  logic          access_ok;
  logic [AW-1:0] idx;
  logic [3:0]    be;

  assign req   = mem_read | mem_write;
  assign stall = ((state == IDLE) && req) || (state == BUSY);
  assign idx   = lat_addr[AW+1:2];
  assign fire  = (state == BUSY) && (count == '0);

`ifdef RAM_RESPONDER_BOUNDS_CHECK_EN
  logic lat_ok;
  logic addr_ok;
  assign addr_ok   = (address[31:AW+2] == '0);
  assign access_ok = lat_ok;
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^address[31:AW+2];
  assign access_ok      = 1'b1;
  assign error          = 1'b0;
`endif

  // Lane enables; input_data is already lane-aligned so no data steering is needed
  always_comb begin
    be = 4'b1111;
    case (lat_len)
      3'd0:    be = 4'b0001 << lat_addr[1:0];
      3'd1:    be = lat_addr[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  // Storage is never reset; writes only land on the BUSY -> DONE edge
  always_ff @(posedge clock) begin
    if (fire && lat_wr && access_ok && !reset) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= lat_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      count       <= '0;
      output_data <= '0;
      ready       <= 1'b0;
      lat_addr    <= '0;
      lat_data    <= '0;
      lat_len     <= '0;
      lat_wr      <= 1'b0;
      lat_rd      <= 1'b0;
`ifdef RAM_RESPONDER_BOUNDS_CHECK_EN
      lat_ok      <= 1'b0;
      error       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            state    <= BUSY;
            count    <= CW'(LATENCY - 1);
            lat_addr <= address[AW+1:0];
            lat_data <= input_data;
            lat_len  <= mem_op_length;
            lat_wr   <= mem_write;
            lat_rd   <= mem_read & ~mem_write;
`ifdef RAM_RESPONDER_BOUNDS_CHECK_EN
            lat_ok   <= addr_ok;
`endif
          end
        end
        BUSY: begin
          if (count == '0) begin
            state       <= DONE;
            ready       <= 1'b1;
            output_data <= (lat_rd && access_ok) ? mem[idx] : '0;
`ifdef RAM_RESPONDER_BOUNDS_CHECK_EN
            error       <= ~lat_ok;
`endif
          end else begin
            count <= count - 1'b1;
          end
        end
        DONE: begin
          state       <= IDLE;
          ready       <= 1'b0;
          output_data <= '0;
`ifdef RAM_RESPONDER_BOUNDS_CHECK_EN
          error       <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder: default instance plus a LATENCY=1 instance.
module tb_ram_responder;

  logic        clock;
  logic        reset;
  logic [31:0] address;
  logic [31:0] input_data;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  mem_op_length;
  logic [31:0] output_data;
  logic        stall;
  logic        ready;
  logic        error;

  logic [31:0] l1_address;
  logic [31:0] l1_input_data;
  logic        l1_read;
  logic        l1_write;
  logic [2:0]  l1_len;
  logic [31:0] l1_od;
  logic        l1_stall;
  logic        l1_ready;
  logic        l1_error;

  int checks;
  int errors;

  logic [31:0] r_od;
  logic        r_err;
  int          r_edges;
  int          r_stalls;
  logic        r_done_stall;
  logic        r_post_ready;
  logic [31:0] r_post_od;
  logic        r_post_err;

  ram_responder u_dut (
    .clock        (clock),
    .reset        (reset),
    .address      (address),
    .input_data   (input_data),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_op_length(mem_op_length),
    .output_data  (output_data),
    .stall        (stall),
    .ready        (ready),
    .error        (error)
  );

  ram_responder #(.WORDS(16), .LATENCY(1)) u_l1 (
    .clock        (clock),
    .reset        (reset),
    .address      (l1_address),
    .input_data   (l1_input_data),
    .mem_read     (l1_read),
    .mem_write    (l1_write),
    .mem_op_length(l1_len),
    .output_data  (l1_od),
    .stall        (l1_stall),
    .ready        (l1_ready),
    .error        (l1_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request on the default instance; results land in the r_* variables
  task access(input logic rd, input logic wr, input logic [31:0] a,
              input logic [31:0] d, input logic [2:0] len);
    @(negedge clock);
    address = a; input_data = d; mem_read = rd; mem_write = wr; mem_op_length = len;
    r_edges = 0; r_stalls = 0;
    #1;
    while (ready !== 1'b1 && r_edges < 20) begin
      if (stall === 1'b1) r_stalls++;
      @(posedge clock);
      r_edges++;
      #1;
      mem_read = 1'b0; mem_write = 1'b0;
    end
    r_od = output_data;
    r_err = error;
    r_done_stall = stall;
    @(posedge clock);
    #1;
    r_post_ready = ready;
    r_post_od = output_data;
    r_post_err = error;
  endtask

  initial begin
    logic       saw_ready;
    logic [8:0] stall_seq;
    logic [8:0] ready_seq;
    logic [31:0] od_k5;

    checks = 0; errors = 0;
    reset = 1'b1;
    address = '0; input_data = '0; mem_read = 1'b0; mem_write = 1'b0; mem_op_length = '0;
    l1_address = '0; l1_input_data = '0; l1_read = 1'b0; l1_write = 1'b0; l1_len = '0;
    stall_seq = '0; ready_seq = '0; od_k5 = '0;

    repeat (2) @(negedge clock);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_od", output_data, 32'd0);
    check("rst_error", 32'(error), 32'd0);
    reset = 1'b0;

    // Scenario 1: word write then read, timing and stall length
    access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 3'd2);
    check("s1_wr_edges", 32'(r_edges), 32'd5);
    check("s1_wr_stalls", 32'(r_stalls), 32'd5);
    check("s1_wr_done_stall", 32'(r_done_stall), 32'd0);
    access(1'b1, 1'b0, 32'h10, 32'h0, 3'd2);
    check("s1_rd_data", r_od, 32'hDEADBEEF);
    check("s1_rd_edges", 32'(r_edges), 32'd5);
    check("s1_rd_stalls", 32'(r_stalls), 32'd5);
    check("s1_post_ready", 32'(r_post_ready), 32'd0);
    check("s1_post_od", r_post_od, 32'd0);

    // Scenario 2: byte and halfword merges
    access(1'b0, 1'b1, 32'h10, 32'h0, 3'd2);
    access(1'b0, 1'b1, 32'h13, 32'hAA000000, 3'd0);
    access(1'b0, 1'b1, 32'h10, 32'h00005566, 3'd1);
    access(1'b1, 1'b0, 32'h10, 32'h0, 3'd2);
    check("s2_merge", r_od, 32'hAA005566);
    access(1'b0, 1'b1, 32'h14, 32'h01020304, 3'd2);
    access(1'b0, 1'b1, 32'h17, 32'hBEEF0000, 3'd1);
    access(1'b0, 1'b1, 32'h15, 32'h0000CC00, 3'd0);
    access(1'b1, 1'b0, 32'h16, 32'h0, 3'd0);
    check("s2_merge_hi", r_od, 32'hBEEFCC04);

    // Scenario 3: simultaneous read and write, write wins
    access(1'b1, 1'b1, 32'h20, 32'h12345678, 3'd2);
    check("s3_both_od", r_od, 32'd0);
    access(1'b1, 1'b0, 32'h20, 32'h0, 3'd2);
    check("s3_readback", r_od, 32'h12345678);

    // Scenario 4: reset aborts an in-flight write
    access(1'b0, 1'b1, 32'h40, 32'h11111111, 3'd2);
    @(negedge clock);
    address = 32'h40; input_data = 32'hCAFEF00D; mem_write = 1'b1; mem_op_length = 3'd2;
    @(posedge clock);
    #1;
    mem_write = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    check("s4_rst_ready", 32'(ready), 32'd0);
    check("s4_rst_stall", 32'(stall), 32'd0);
    saw_ready = 1'b0;
    repeat (2) begin
      @(negedge clock);
      if (ready === 1'b1) saw_ready = 1'b1;
    end
    reset = 1'b0;
    repeat (6) begin
      @(negedge clock);
      if (ready === 1'b1) saw_ready = 1'b1;
    end
    check("s4_no_ready", 32'(saw_ready), 32'd0);
    check("s4_stall_after", 32'(stall), 32'd0);
    access(1'b1, 1'b0, 32'h40, 32'h0, 3'd2);
    check("s4_old_data", r_od, 32'h11111111);

    // Scenario 5: out-of-range write
    access(1'b0, 1'b1, 32'h0, 32'h55555555, 3'd2);
    access(1'b0, 1'b1, 32'h1000, 32'h00000099, 3'd2);
    check("s5_wr_edges", 32'(r_edges), 32'd5);
    check("s5_err_after", 32'(r_post_err), 32'd0);
`ifdef RAM_RESPONDER_BOUNDS_CHECK_EN
    check("s5_err_done", 32'(r_err), 32'd1);
    access(1'b1, 1'b0, 32'h0, 32'h0, 3'd2);
    check("s5_word0", r_od, 32'h55555555);
    check("s5_word0_err", 32'(r_err), 32'd0);
    access(1'b1, 1'b0, 32'h1000, 32'h0, 3'd2);
    check("s5_oor_read", r_od, 32'd0);
    check("s5_oor_read_err", 32'(r_err), 32'd1);
`else
    check("s5_err_done", 32'(r_err), 32'd0);
    access(1'b1, 1'b0, 32'h0, 32'h0, 3'd2);
    check("s5_word0", r_od, 32'h00000099);
    access(1'b1, 1'b0, 32'h1000, 32'h0, 3'd2);
    check("s5_wrap_read", r_od, 32'h00000099);
`endif

    // Scenario 6: LATENCY=1 instance with a continuously held read
    @(negedge clock);
    l1_address = 32'h8; l1_input_data = 32'h0000ABCD; l1_len = 3'd2; l1_write = 1'b1;
    @(posedge clock);
    #1;
    l1_write = 1'b0;
    for (int i = 0; i < 10 && l1_ready !== 1'b1; i++) @(negedge clock);
    check("s6_wr_ready", 32'(l1_ready), 32'd1);
    @(negedge clock);
    l1_read = 1'b1;
    #1;
    for (int k = 0; k < 9; k++) begin
      if (k > 0) @(negedge clock);
      stall_seq[k] = l1_stall;
      ready_seq[k] = l1_ready;
      if (k == 5) od_k5 = l1_od;
    end
    l1_read = 1'b0;
    check("s6_stall_seq", 32'(stall_seq), 32'(9'b011011011));
    check("s6_ready_seq", 32'(ready_seq), 32'(9'b100100100));
    check("s6_read_data", od_k5, 32'h0000ABCD);
    check("s6_error", 32'(l1_error), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
